// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: bus widths, load-op bit indices
// and packed layouts of the exe->mem and mem->wb bundles.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 140;
  localparam int MS_TO_WS_BUS_WD = 126;
  localparam int STALL_BUS_WD    = 10;
  localparam int FORWARD_BUS_WD  = 33;

  // ld_extd_op one-hot {lw,lhu,lh,lbu,lb}
  localparam int LD_LB  = 0;
  localparam int LD_LBU = 1;
  localparam int LD_LH  = 2;
  localparam int LD_LHU = 3;
  localparam int LD_LW  = 4;

  typedef struct packed {
    logic [6:0]  rsvd;
    logic        tlbr;
    logic        tlbwi;
    logic        tlbp;
    logic [31:0] cp0_index_wdata;
    logic        bd;
    logic        exc;
    logic [7:0]  exc_type;
    logic        eret;
    logic        cp0_wen;
    logic        res_from_cp0;
    logic [7:0]  cp0_addr;
    logic        res_from_mem;
    logic        store_op;
    logic [4:0]  ld_extd_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

  typedef struct packed {
    logic        tlbr;
    logic        tlbwi;
    logic        tlbp;
    logic [31:0] cp0_index_wdata;
    logic        bd;
    logic        exc;
    logic [7:0]  exc_type;
    logic        eret;
    logic        cp0_wen;
    logic        res_from_cp0;
    logic [7:0]  cp0_addr;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_ld_extend.sv
// Load data extraction: picks byte/half by address and
// sign/zero extends to 32 bits; lw passes through.
module mem_stage_ld_extend
  import mem_stage_pkg::*;
(
  input  logic [4:0]  ld_extd_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // select the addressed byte/half, then extend by op
  always_comb begin
    byte_sel = rdata[7:0];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    unique case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    result = rdata;
    unique case (1'b1)
      ld_extd_op[LD_LB]:  result = {{24{byte_sel[7]}}, byte_sel};
      ld_extd_op[LD_LBU]: result = {24'd0, byte_sel};
      ld_extd_op[LD_LH]:  result = {{16{half_sel[15]}}, half_sel};
      ld_extd_op[LD_LHU]: result = {16'd0, half_sel};
      ld_extd_op[LD_LW]:  result = rdata;
      default:            result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: waits for data_ok, buffers early responses, drops stale ones.
// Optional MS_LOAD_FWD_EN lets a completed load forward its result.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DROP_W = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [STALL_BUS_WD-1:0]    stall_ms_bus,
  output logic [FORWARD_BUS_WD-1:0]  forward_ms_bus,
  output logic [1:0]                 ms_exc_eret_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata
);

  localparam int SW = DROP_W + 1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  es_to_ms_t         es_in;
  es_to_ms_t         ms_r;
  ms_to_ws_t         ws_o;
  logic              ms_valid;
  logic              wait_data;
  logic              rbuf_valid;
  logic [31:0]       rbuf;
  logic [DROP_W-1:0] drop_cnt;
  logic [DROP_W-1:0] drop_nxt;
  logic [SW-1:0]     drop_sum;
  logic [1:0]        drop_inc;
  logic              drop_dec;
  logic              drop_ovf;
  logic              data_ok_acc;
  logic              ms_ready_go;
  logic              rbuf_fill;
  logic              es_mem;
  logic              fwd_valid;
  logic [31:0]       ld_data;
  logic [31:0]       ld_result;
  logic [31:0]       final_result;

  assign es_in       = es_to_ms_bus;
  assign es_mem      = es_in.res_from_mem | es_in.store_op;
  assign data_ok_acc = data_sram_data_ok && (drop_cnt == '0);
  assign ms_ready_go = !wait_data || rbuf_valid || data_ok_acc;
  assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
  assign rbuf_fill   = ms_valid && wait_data && !rbuf_valid
                    && data_ok_acc && !ws_allowin;
  assign ld_data     = rbuf_valid ? rbuf : data_sram_rdata;

  mem_stage_ld_extend u_ld_extend (
    .ld_extd_op (ms_r.ld_extd_op),
    .addr       (ms_r.alu_result[1:0]),
    .rdata      (ld_data),
    .result     (ld_result)
  );

  assign final_result = ms_r.res_from_mem ? ld_result : ms_r.alu_result;

  // stale-response accounting across a flush
  always_comb begin
    drop_dec = data_sram_data_ok && (drop_cnt != '0);
    drop_inc = {1'b0, flush && ms_valid && wait_data
                      && !rbuf_valid && !data_ok_acc}
             + {1'b0, flush && es_to_ms_valid && es_mem};
    drop_sum = {1'b0, drop_cnt} + SW'(drop_inc) - SW'(drop_dec);
    drop_ovf = drop_sum > {1'b0, DROP_MAX};
    drop_nxt = drop_ovf ? DROP_MAX : drop_sum[DROP_W-1:0];
  end

  // stage valid, wait and buffer-valid state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid   <= 1'b0;
      wait_data  <= 1'b0;
      rbuf_valid <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drop_cnt <= drop_nxt;
      if (flush) begin
        ms_valid   <= 1'b0;
        wait_data  <= 1'b0;
        rbuf_valid <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid   <= es_to_ms_valid;
        wait_data  <= es_to_ms_valid && es_mem;
        rbuf_valid <= 1'b0;
      end else if (rbuf_fill) begin
        rbuf_valid <= 1'b1;
      end
    end
  end

  // payload and response buffer registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_r <= '0;
      rbuf <= '0;
    end else begin
      if (es_to_ms_valid && ms_allowin) ms_r <= es_in;
      if (rbuf_fill) rbuf <= data_sram_rdata;
    end
  end

  drop_no_overflow: assert property (
    @(posedge clk) disable iff (!resetn) !drop_ovf
  );

`ifdef MS_LOAD_FWD_EN
  assign fwd_valid = ms_valid && !ms_r.res_from_cp0
                  && (!ms_r.res_from_mem || ms_ready_go);
`else
  assign fwd_valid = ms_valid && !ms_r.res_from_mem
                  && !ms_r.res_from_cp0;
`endif

  // assemble the outgoing wb bundle
  always_comb begin
    ws_o                 = '0;
    ws_o.tlbr            = ms_r.tlbr;
    ws_o.tlbwi           = ms_r.tlbwi;
    ws_o.tlbp            = ms_r.tlbp;
    ws_o.cp0_index_wdata = ms_r.cp0_index_wdata;
    ws_o.bd              = ms_r.bd;
    ws_o.exc             = ms_r.exc;
    ws_o.exc_type        = ms_r.exc_type;
    ws_o.eret            = ms_r.eret;
    ws_o.cp0_wen         = ms_r.cp0_wen;
    ws_o.res_from_cp0    = ms_r.res_from_cp0;
    ws_o.cp0_addr        = ms_r.cp0_addr;
    ws_o.gr_we           = ms_r.gr_we;
    ws_o.dest            = ms_r.dest;
    ws_o.final_result    = final_result;
    ws_o.pc              = ms_r.pc;
  end

  assign ms_to_ws_valid  = ms_valid && ms_ready_go;
  assign ms_to_ws_bus    = ws_o;
  assign stall_ms_bus    = {{5{ms_valid && ms_r.gr_we}}, ms_r.dest};
  assign forward_ms_bus  = {fwd_valid, final_result};
  assign ms_exc_eret_bus = {ms_valid && ms_r.exc, ms_valid && ms_r.eret};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: load-extend vector table, scoreboarded wb
// handoffs and hand sequences for waits, buffering, flush drops.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                       clk;
  logic                       resetn;
  logic                       flush;
  logic                       ws_allowin;
  logic                       ms_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [STALL_BUS_WD-1:0]    stall_ms_bus;
  logic [FORWARD_BUS_WD-1:0]  forward_ms_bus;
  logic [1:0]                 ms_exc_eret_bus;
  logic                       data_sram_data_ok;
  logic [31:0]                data_sram_rdata;

  mem_stage #(.DROP_W(2)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .flush             (flush),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .stall_ms_bus      (stall_ms_bus),
    .forward_ms_bus    (forward_ms_bus),
    .ms_exc_eret_bus   (ms_exc_eret_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] res;
    logic        exc;
    logic [7:0]  et;
    logic [4:0]  dest;
  } exp_t;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic        ldm;
    logic        st;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  localparam logic [4:0] OP_LB  = 5'b00001;
  localparam logic [4:0] OP_LBU = 5'b00010;
  localparam logic [4:0] OP_LH  = 5'b00100;
  localparam logic [4:0] OP_LHU = 5'b01000;
  localparam logic [4:0] OP_LW  = 5'b10000;

  exp_t sbq[$];
  vec_t vt[11];
  int   checks;
  int   errs;

`ifdef MS_LOAD_FWD_EN
  localparam logic LD_FWD = 1'b1;
`else
  localparam logic LD_FWD = 1'b0;
`endif

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  function automatic es_to_ms_t mk(input logic [4:0] op,
      input logic ldm, input logic st, input logic [31:0] alu,
      input logic [31:0] pc, input logic exc, input logic [7:0] et);
    es_to_ms_t e;
    e              = '0;
    e.ld_extd_op   = op;
    e.res_from_mem = ldm;
    e.store_op     = st;
    e.alu_result   = alu;
    e.pc           = pc;
    e.gr_we        = !st;
    e.dest         = pc[6:2];
    e.exc          = exc;
    e.exc_type     = et;
    return e;
  endfunction

  function automatic exp_t ex(input es_to_ms_t e,
                              input logic [31:0] res);
    exp_t x;
    x.pc   = e.pc;
    x.res  = res;
    x.exc  = e.exc;
    x.et   = e.exc_type;
    x.dest = e.dest;
    return x;
  endfunction

  // sample point: scoreboard any wb handoff seen this cycle
  task automatic smp();
    ms_to_ws_t o;
    exp_t      a;
    exp_t      w;
    @(negedge clk);
    if (ms_to_ws_valid && ws_allowin) begin
      o = ms_to_ws_bus;
      a.pc = o.pc; a.res = o.final_result; a.exc = o.exc;
      a.et = o.exc_type; a.dest = o.dest;
      if (sbq.size() == 0) begin
        checks++; errs++;
        $display("FAIL sb_unexpected: got %h want none", a);
      end else begin
        w = sbq.pop_front();
        chk("sb_result", 64'(a), 64'(w));
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    smp();
    adv();
  endtask

  task automatic send(input es_to_ms_t e);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = e;
    smp();
    chk("accept", 64'(ms_allowin), 64'd1);
    adv();
    es_to_ms_valid = 1'b0;
  endtask

  initial begin
    es_to_ms_t e;
    checks = 0;
    errs   = 0;
    vt[0]  = '{"lw",    OP_LW,  1, 0, 32'h0000_1004, 32'h8765_4321, 32'h8765_4321};
    vt[1]  = '{"lb3",   OP_LB,  1, 0, 32'h0000_2003, 32'h8012_3456, 32'hFFFF_FF80};
    vt[2]  = '{"lbu3",  OP_LBU, 1, 0, 32'h0000_2003, 32'h8012_3456, 32'h0000_0080};
    vt[3]  = '{"lh2",   OP_LH,  1, 0, 32'h0000_3002, 32'h8001_1234, 32'hFFFF_8001};
    vt[4]  = '{"lhu2",  OP_LHU, 1, 0, 32'h0000_3002, 32'h8001_1234, 32'h0000_8001};
    vt[5]  = '{"lb0",   OP_LB,  1, 0, 32'h0000_4000, 32'h1234_5678, 32'h0000_0078};
    vt[6]  = '{"lb1",   OP_LB,  1, 0, 32'h0000_4001, 32'h0000_A500, 32'hFFFF_FFA5};
    vt[7]  = '{"lh0",   OP_LH,  1, 0, 32'h0000_5000, 32'hFFFF_7FFF, 32'h0000_7FFF};
    vt[8]  = '{"lbu2",  OP_LBU, 1, 0, 32'h0000_6002, 32'h00C3_0000, 32'h0000_00C3};
    vt[9]  = '{"add",   5'd0,   0, 0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678};
    vt[10] = '{"store", 5'd0,   0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100};

    resetn            = 1'b0;
    flush             = 1'b0;
    ws_allowin        = 1'b1;
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    repeat (2) @(posedge clk);
    smp();
    chk("rst_ws_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("rst_allowin", 64'(ms_allowin), 64'd1);
    chk("rst_stall", 64'(stall_ms_bus), 64'd0);
    chk("rst_fwd_valid", 64'(forward_ms_bus[32]), 64'd0);
    chk("rst_exc_eret", 64'(ms_exc_eret_bus), 64'd0);
    adv();
    resetn = 1'b1;
    adv();

    // vector table: one entry each, response on the next cycle
    for (int i = 0; i < 11; i++) begin
      e = mk(vt[i].op, vt[i].ldm, vt[i].st, vt[i].alu,
             32'hBFC0_0000 + 32'(i * 4), 1'b0, 8'h00);
      sbq.push_back(ex(e, vt[i].exp));
      send(e);
      if (vt[i].ldm || vt[i].st) begin
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = vt[i].rdata;
      end
      cyc();
      data_sram_data_ok = 1'b0;
      chk({"drain_", vt[i].name}, 64'(sbq.size()), 64'd0);
    end

    // lw waits three cycles for data_ok
    e = mk(OP_LW, 1, 0, 32'h0000_1004, 32'hBFC0_0100, 1'b0, 8'h00);
    sbq.push_back(ex(e, 32'h8765_4321));
    send(e);
    for (int k = 0; k < 2; k++) begin
      smp();
      chk("lw_wait_valid", 64'(ms_to_ws_valid), 64'd0);
      chk("lw_wait_allowin", 64'(ms_allowin), 64'd0);
      chk("lw_wait_stall", 64'(stall_ms_bus), {54'd0, 5'h1F, e.dest});
      chk("lw_wait_fwd", 64'(forward_ms_bus[32]), 64'd0);
      adv();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h8765_4321;
    smp();
    chk("lw_done_valid", 64'(ms_to_ws_valid), 64'd1);
    chk("lw_done_fwd", 64'(forward_ms_bus[32]), 64'(LD_FWD));
    adv();
    data_sram_data_ok = 1'b0;
    chk("lw_drain", 64'(sbq.size()), 64'd0);

    // data_ok while wb is blocked: buffered value delivered later
    e = mk(OP_LW, 1, 0, 32'h0000_7000, 32'hBFC0_0200, 1'b0, 8'h00);
    sbq.push_back(ex(e, 32'hAAAA_5555));
    send(e);
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hAAAA_5555;
    smp();
    chk("buf_valid0", 64'(ms_to_ws_valid), 64'd1);
    chk("buf_allowin0", 64'(ms_allowin), 64'd0);
    adv();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("buf_hold_valid", 64'(ms_to_ws_valid), 64'd1);
      chk("buf_hold_allowin", 64'(ms_allowin), 64'd0);
      adv();
    end
    ws_allowin = 1'b1;
    smp();
    chk("buf_handoff_allowin", 64'(ms_allowin), 64'd1);
    adv();
    chk("buf_drain", 64'(sbq.size()), 64'd0);

    // flush with a waiting lw and an issued exe lw: two drops
    e = mk(OP_LW, 1, 0, 32'h0000_8000, 32'hBFC0_0300, 1'b0, 8'h00);
    send(e);
    flush          = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(OP_LW, 1, 0, 32'h0000_8004,
                        32'hBFC0_0304, 1'b0, 8'h00);
    cyc();
    flush          = 1'b0;
    es_to_ms_valid = 1'b0;
    smp();
    chk("flush_valid", 64'(ms_to_ws_valid), 64'd0);
    adv();
    e = mk(OP_LW, 1, 0, 32'h0000_9000, 32'hBFC0_0400, 1'b0, 8'h00);
    sbq.push_back(ex(e, 32'h1357_2468));
    send(e);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_BAD1;
    smp();
    chk("drop1_valid", 64'(ms_to_ws_valid), 64'd0);
    adv();
    data_sram_rdata = 32'h0000_BAD2;
    smp();
    chk("drop2_valid", 64'(ms_to_ws_valid), 64'd0);
    adv();
    data_sram_rdata = 32'h1357_2468;
    smp();
    chk("drop_done_valid", 64'(ms_to_ws_valid), 64'd1);
    adv();
    data_sram_data_ok = 1'b0;
    chk("drop_drain", 64'(sbq.size()), 64'd0);

    // add: single-cycle pass, forwards its result
    e = mk(5'd0, 0, 0, 32'h0F0F_1234, 32'hBFC0_0500, 1'b0, 8'h00);
    sbq.push_back(ex(e, 32'h0F0F_1234));
    send(e);
    smp();
    chk("add_fwd", 64'(forward_ms_bus), {31'd0, 1'b1, 32'h0F0F_1234});
    adv();
    chk("add_drain", 64'(sbq.size()), 64'd0);

    // faulting store still waits, exc reaches wb unchanged
    e = mk(5'd0, 0, 1, 32'h0000_2001, 32'hBFC0_0600, 1'b1, 8'h10);
    sbq.push_back(ex(e, 32'h0000_2001));
    send(e);
    smp();
    chk("exc_bus", 64'(ms_exc_eret_bus), 64'd2);
    chk("exc_wait_valid", 64'(ms_to_ws_valid), 64'd0);
    adv();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0;
    cyc();
    data_sram_data_ok = 1'b0;
    smp();
    chk("exc_bus_clear", 64'(ms_exc_eret_bus), 64'd0);
    adv();

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
